// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the PC, reads a 1-cycle synchronous ROM and hands {adef, pc, inst} to decode.
// Latency 3 cycles from an accepted next_fetch to IF_over; next_fetch only acts in DONE/HOLD, otherwise the stage stalls in HOLD.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        next_fetch,
    input  logic        jbr_taken,
    input  logic [31:0] jbr_target,
    input  logic        exc_valid,
    input  logic [31:0] exc_pc,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst,
    output logic        IF_valid,
    output logic        IF_over,
    output logic [64:0] IF_ID_bus,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst,
    output logic [1:0]  IF_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_r_q, inst_r_d;
    logic [31:0] pc_r_q, pc_r_d;
    logic        adef_r_q, adef_r_d;

    logic        fetch_accept;
    logic [31:0] pc_seq;
    logic [31:0] pc_next;

    assign fetch_accept = next_fetch && ((state_q == S_DONE) || (state_q == S_HOLD));
    assign pc_seq       = pc_q + 32'd4;

    // Exception/return beats branch, branch beats sequential.
    always_comb begin
        pc_next = pc_seq;
        if (exc_valid) begin
            pc_next = exc_pc;
        end else if (jbr_taken) begin
            pc_next = jbr_target;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_r_d = inst_r_q;
        pc_r_d   = pc_r_q;
        adef_r_d = adef_r_q;
        case (state_q)
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                state_d  = S_DONE;
                inst_r_d = inst;
                pc_r_d   = pc_q;
                adef_r_d = (pc_q[1:0] != 2'b00);
            end
            S_DONE:  state_d = next_fetch ? S_FETCH : S_HOLD;
            S_HOLD:  state_d = next_fetch ? S_FETCH : S_HOLD;
            default: state_d = S_FETCH;
        endcase
        if (fetch_accept) begin
            pc_d = pc_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            inst_r_q <= 32'd0;
            pc_r_q   <= 32'd0;
            adef_r_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_r_q <= inst_r_d;
            pc_r_q   <= pc_r_d;
            adef_r_q <= adef_r_d;
        end
    end

    assign inst_addr = pc_q;
    assign IF_valid  = (state_q != S_HOLD);
    assign IF_over   = (state_q == S_DONE);
    assign IF_ID_bus = {adef_r_q, pc_r_q, inst_r_q};
    assign IF_pc     = pc_r_q;
    assign IF_inst   = inst_r_q;
    assign IF_state  = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural 1-cycle synchronous ROM.
module tb_fetch_stage;

    logic        clk;
    logic        resetn;
    logic        next_fetch;
    logic        jbr_taken;
    logic [31:0] jbr_target;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        IF_valid;
    logic        IF_over;
    logic [64:0] IF_ID_bus;
    logic [31:0] IF_pc;
    logic [31:0] IF_inst;
    logic [1:0]  IF_state;

    int n_cmp = 0;
    int n_err = 0;

    fetch_stage dut (
        .clk        (clk),
        .resetn     (resetn),
        .next_fetch (next_fetch),
        .jbr_taken  (jbr_taken),
        .jbr_target (jbr_target),
        .exc_valid  (exc_valid),
        .exc_pc     (exc_pc),
        .inst_addr  (inst_addr),
        .inst       (inst),
        .IF_valid   (IF_valid),
        .IF_over    (IF_over),
        .IF_ID_bus  (IF_ID_bus),
        .IF_pc      (IF_pc),
        .IF_inst    (IF_inst),
        .IF_state   (IF_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h2408_0005;
        return {a[15:0], ~a[15:0]};
    endfunction

    always @(posedge clk) inst <= rom_word(inst_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        next_fetch = 1'b0;
        jbr_taken  = 1'b0;
        jbr_target = 32'd0;
        exc_valid  = 1'b0;
        exc_pc     = 32'd0;
    endtask

    task automatic test_reset();
        clear_req();
        resetn = 1'b0;
        #2;
        n_cmp++; if (IF_state !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", IF_state); end
        n_cmp++; if (inst_addr !== 32'd0) begin n_err++; $display("FAIL rst_addr got %h want 0", inst_addr); end
        n_cmp++; if (IF_valid !== 1'b1) begin n_err++; $display("FAIL rst_valid got %b want 1", IF_valid); end
        n_cmp++; if (IF_over !== 1'b0) begin n_err++; $display("FAIL rst_over got %b want 0", IF_over); end
        n_cmp++; if (IF_ID_bus !== 65'd0) begin n_err++; $display("FAIL rst_bus got %h want 0", IF_ID_bus); end
        n_cmp++; if (IF_pc !== 32'd0 || IF_inst !== 32'd0) begin n_err++; $display("FAIL rst_disp got %h/%h want 0/0", IF_pc, IF_inst); end
        tick();
        tick();
        resetn = 1'b1;
        #1;
        n_cmp++; if (IF_state !== 2'd0 || IF_over !== 1'b0) begin n_err++; $display("FAIL first_c0 got st=%0d over=%b want 0/0", IF_state, IF_over); end
        tick();
        n_cmp++; if (IF_state !== 2'd1 || IF_over !== 1'b0) begin n_err++; $display("FAIL first_c1 got st=%0d over=%b want 1/0", IF_state, IF_over); end
        tick();
        n_cmp++; if (IF_state !== 2'd2 || IF_over !== 1'b1) begin n_err++; $display("FAIL first_c2 got st=%0d over=%b want 2/1", IF_state, IF_over); end
        n_cmp++; if (IF_ID_bus !== {1'b0, 32'h0, 32'h2408_0005}) begin n_err++; $display("FAIL first_bus got %h want %h", IF_ID_bus, {1'b0, 32'h0, 32'h2408_0005}); end
        tick();
        n_cmp++; if (IF_state !== 2'd3 || IF_over !== 1'b0 || IF_valid !== 1'b0) begin n_err++; $display("FAIL first_hold got st=%0d over=%b vld=%b want 3/0/0", IF_state, IF_over, IF_valid); end
        n_cmp++; if (IF_ID_bus !== {1'b0, 32'h0, 32'h2408_0005}) begin n_err++; $display("FAIL hold_bus got %h want %h", IF_ID_bus, {1'b0, 32'h0, 32'h2408_0005}); end
    endtask

    task automatic test_sequential();
        next_fetch = 1'b1;
        tick();
        clear_req();
        n_cmp++; if (IF_state !== 2'd0 || inst_addr !== 32'h4) begin n_err++; $display("FAIL seq_addr got st=%0d addr=%h want 0/4", IF_state, inst_addr); end
        tick();
        n_cmp++; if (IF_over !== 1'b0) begin n_err++; $display("FAIL seq_early_over got %b want 0", IF_over); end
        tick();
        n_cmp++; if (IF_over !== 1'b1 || IF_pc !== 32'h4) begin n_err++; $display("FAIL seq_done got over=%b pc=%h want 1/4", IF_over, IF_pc); end
        n_cmp++; if (IF_ID_bus !== {1'b0, 32'h4, rom_word(32'h4)}) begin n_err++; $display("FAIL seq_bus got %h want %h", IF_ID_bus, {1'b0, 32'h4, rom_word(32'h4)}); end
        tick();
        tick();
        n_cmp++; if (IF_state !== 2'd3 || IF_pc !== 32'h4 || IF_inst !== rom_word(32'h4) || IF_over !== 1'b0) begin
            n_err++; $display("FAIL seq_hold got st=%0d pc=%h inst=%h over=%b", IF_state, IF_pc, IF_inst, IF_over); end
    endtask

    task automatic test_branch();
        next_fetch = 1'b1; jbr_taken = 1'b1; jbr_target = 32'h40;
        tick();
        clear_req();
        n_cmp++; if (inst_addr !== 32'h40) begin n_err++; $display("FAIL br_addr got %h want 40", inst_addr); end
        tick(); tick();
        n_cmp++; if (IF_ID_bus !== {1'b0, 32'h40, rom_word(32'h40)}) begin n_err++; $display("FAIL br_bus got %h want %h", IF_ID_bus, {1'b0, 32'h40, rom_word(32'h40)}); end
        tick();
        next_fetch = 1'b1; jbr_taken = 1'b1; jbr_target = 32'h40; exc_valid = 1'b1; exc_pc = 32'h380;
        tick();
        clear_req();
        n_cmp++; if (inst_addr !== 32'h380) begin n_err++; $display("FAIL exc_prio_addr got %h want 380", inst_addr); end
        tick(); tick();
        n_cmp++; if (IF_over !== 1'b1 || IF_ID_bus !== {1'b0, 32'h380, rom_word(32'h380)}) begin
            n_err++; $display("FAIL exc_bus got over=%b bus=%h want 1/%h", IF_over, IF_ID_bus, {1'b0, 32'h380, rom_word(32'h380)}); end
        tick();
    endtask

    task automatic test_misaligned_wrap();
        next_fetch = 1'b1; jbr_taken = 1'b1; jbr_target = 32'h42;
        tick();
        clear_req();
        n_cmp++; if (inst_addr !== 32'h42) begin n_err++; $display("FAIL mis_addr got %h want 42", inst_addr); end
        tick(); tick();
        n_cmp++; if (IF_ID_bus !== {1'b1, 32'h42, rom_word(32'h42)}) begin n_err++; $display("FAIL mis_bus got %h want %h", IF_ID_bus, {1'b1, 32'h42, rom_word(32'h42)}); end
        tick();
        next_fetch = 1'b1; jbr_taken = 1'b1; jbr_target = 32'hFFFF_FFFC;
        tick();
        clear_req();
        tick(); tick();
        n_cmp++; if (IF_ID_bus !== {1'b0, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC)}) begin
            n_err++; $display("FAIL top_bus got %h want %h", IF_ID_bus, {1'b0, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC)}); end
        tick();
        next_fetch = 1'b1;
        tick();
        clear_req();
        n_cmp++; if (inst_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr got %h want 0", inst_addr); end
        tick(); tick();
        n_cmp++; if (IF_ID_bus !== {1'b0, 32'h0, 32'h2408_0005}) begin n_err++; $display("FAIL wrap_bus got %h want %h", IF_ID_bus, {1'b0, 32'h0, 32'h2408_0005}); end
        tick();
    endtask

    task automatic test_ignored();
        next_fetch = 1'b1;
        tick();
        // pc is now 4 in FETCH; requests in FETCH and WAIT must not redirect
        jbr_taken = 1'b1; jbr_target = 32'h100; exc_valid = 1'b1; exc_pc = 32'h200;
        tick();
        n_cmp++; if (IF_state !== 2'd1 || inst_addr !== 32'h4 || IF_over !== 1'b0) begin
            n_err++; $display("FAIL ign_wait got st=%0d addr=%h over=%b want 1/4/0", IF_state, inst_addr, IF_over); end
        tick();
        clear_req();
        n_cmp++; if (IF_state !== 2'd2 || inst_addr !== 32'h4 || IF_over !== 1'b1) begin
            n_err++; $display("FAIL ign_done got st=%0d addr=%h over=%b want 2/4/1", IF_state, inst_addr, IF_over); end
        tick();
        n_cmp++; if (IF_state !== 2'd3 || inst_addr !== 32'h4 || IF_over !== 1'b0 || IF_pc !== 32'h4) begin
            n_err++; $display("FAIL ign_hold got st=%0d addr=%h over=%b pc=%h", IF_state, inst_addr, IF_over, IF_pc); end
    endtask

    task automatic test_back_to_back();
        next_fetch = 1'b1;
        tick();
        tick(); tick();
        n_cmp++; if (IF_over !== 1'b1 || IF_pc !== 32'h8) begin n_err++; $display("FAIL b2b_first got over=%b pc=%h want 1/8", IF_over, IF_pc); end
        tick();
        n_cmp++; if (IF_state !== 2'd0 || inst_addr !== 32'hC) begin n_err++; $display("FAIL b2b_skip_hold got st=%0d addr=%h want 0/c", IF_state, inst_addr); end
        clear_req();
        tick(); tick();
        n_cmp++; if (IF_over !== 1'b1 || IF_ID_bus !== {1'b0, 32'hC, rom_word(32'hC)}) begin
            n_err++; $display("FAIL b2b_second got over=%b bus=%h want 1/%h", IF_over, IF_ID_bus, {1'b0, 32'hC, rom_word(32'hC)}); end
        tick();
    endtask

    task automatic test_reset_mid();
        next_fetch = 1'b1;
        tick();
        clear_req();
        tick();
        n_cmp++; if (IF_state !== 2'd1 || inst_addr !== 32'h10) begin n_err++; $display("FAIL mid_pre got st=%0d addr=%h want 1/10", IF_state, inst_addr); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (IF_state !== 2'd0 || inst_addr !== 32'h0 || IF_over !== 1'b0 || IF_ID_bus !== 65'd0) begin
            n_err++; $display("FAIL mid_rst got st=%0d addr=%h over=%b bus=%h want 0/0/0/0", IF_state, inst_addr, IF_over, IF_ID_bus); end
        tick();
        resetn = 1'b1;
        tick(); tick();
        n_cmp++; if (IF_over !== 1'b1 || IF_ID_bus !== {1'b0, 32'h0, 32'h2408_0005}) begin
            n_err++; $display("FAIL mid_restart got over=%b bus=%h want 1/%h", IF_over, IF_ID_bus, {1'b0, 32'h0, 32'h2408_0005}); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_misaligned_wrap();
        test_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
